// File: rtl/hash_msg_loader.sv
// Message-block loader for a hash core: gathers 16 bytes, runs the core
// under a watchdog, then holds the core idle for a fixed gap before reloading.
module hash_msg_loader #(
  parameter int TIMEOUT    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       core_done,
  output logic       core_ready,
  output logic [7:0] array_numbers0,
  output logic [7:0] array_numbers1,
  output logic [7:0] array_numbers2,
  output logic [7:0] array_numbers3,
  output logic [7:0] array_numbers4,
  output logic [7:0] array_numbers5,
  output logic [7:0] array_numbers6,
  output logic [7:0] array_numbers7,
  output logic [7:0] array_numbers8,
  output logic [7:0] array_numbers9,
  output logic [7:0] array_numbers10,
  output logic [7:0] array_numbers11,
  output logic [7:0] array_numbers12,
  output logic [7:0] array_numbers13,
  output logic [7:0] array_numbers14,
  output logic [7:0] array_numbers15,
  output logic [7:0] block_count,
  output logic       timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, RUN, GAP} state_t;

  state_t          state;
  logic [4:0]      idx;
  logic [WD_W-1:0] wdog;
  logic [3:0]      gap_cnt;
  logic [7:0]      blk [16];

  assign in_ready = (state == LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      idx         <= 5'd0;
      wdog        <= '0;
      gap_cnt     <= 4'd0;
      core_ready  <= 1'b0;
      block_count <= 8'd0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 16; i++) blk[i] <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            blk[idx[3:0]] <= in_byte;
            if (idx == 5'd15) begin
              idx        <= 5'd0;
              wdog       <= '0;
              core_ready <= 1'b1;
              state      <= RUN;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        RUN: begin
          wdog <= wdog + WD_W'(1);
          // The cycle that would make the count reach TIMEOUT is the last one
          // allowed; a done on that same cycle still wins over the timeout.
          if (core_done || (wdog == WD_W'(TIMEOUT - 1))) begin
            if (!core_done) timeout_err <= 1'b1;
            core_ready  <= 1'b0;
            block_count <= block_count + 8'd1;
            gap_cnt     <= 4'd0;
            state       <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= LOAD;
          else gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign array_numbers0  = blk[0];
  assign array_numbers1  = blk[1];
  assign array_numbers2  = blk[2];
  assign array_numbers3  = blk[3];
  assign array_numbers4  = blk[4];
  assign array_numbers5  = blk[5];
  assign array_numbers6  = blk[6];
  assign array_numbers7  = blk[7];
  assign array_numbers8  = blk[8];
  assign array_numbers9  = blk[9];
  assign array_numbers10 = blk[10];
  assign array_numbers11 = blk[11];
  assign array_numbers12 = blk[12];
  assign array_numbers13 = blk[13];
  assign array_numbers14 = blk[14];
  assign array_numbers15 = blk[15];

endmodule

// File: tb/tb_hash_msg_loader.sv
// Directed bench for hash_msg_loader: a per-cycle behavioural model checked on
// every falling edge, plus literal expectations at the key protocol points.
module tb_hash_msg_loader;
  localparam int TIMEOUT = 63;
  localparam int GAP     = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_byte = 8'd0;
  logic       in_valid = 1'b0;
  logic       core_done = 1'b0;
  logic       in_ready, core_ready, timeout_err;
  logic [7:0] block_count;
  logic [7:0] an [16];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hash_msg_loader #(.TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .core_done(core_done), .core_ready(core_ready),
    .array_numbers0(an[0]),   .array_numbers1(an[1]),   .array_numbers2(an[2]),
    .array_numbers3(an[3]),   .array_numbers4(an[4]),   .array_numbers5(an[5]),
    .array_numbers6(an[6]),   .array_numbers7(an[7]),   .array_numbers8(an[8]),
    .array_numbers9(an[9]),   .array_numbers10(an[10]), .array_numbers11(an[11]),
    .array_numbers12(an[12]), .array_numbers13(an[13]), .array_numbers14(an[14]),
    .array_numbers15(an[15]),
    .block_count(block_count), .timeout_err(timeout_err)
  );

  // Behavioural model: a block is either filling, running for some age, or
  // sitting out a number of gap cycles.
  int       m_filled = 0;
  int       m_run_age = -1;
  int       m_gap_left = 0;
  int       m_blocks = 0;
  bit       m_to = 1'b0;
  bit [7:0] m_bytes [16];

  always @(posedge clk) begin
    if (reset) begin
      m_filled = 0; m_run_age = -1; m_gap_left = 0; m_blocks = 0; m_to = 1'b0;
      for (int i = 0; i < 16; i++) m_bytes[i] = 8'd0;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (m_run_age >= 0) begin
      m_run_age++;
      if (core_done || m_run_age == TIMEOUT) begin
        if (!core_done) m_to = 1'b1;
        m_run_age = -1;
        m_gap_left = GAP;
        m_blocks = (m_blocks + 1) % 256;
      end
    end else if (in_valid) begin
      m_bytes[m_filled] = in_byte;
      m_filled++;
      if (m_filled == 16) begin
        m_filled = 0;
        m_run_age = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model in_ready", int'(in_ready), int'(m_run_age < 0 && m_gap_left == 0));
      chk("model core_ready", int'(core_ready), int'(m_run_age >= 0));
      chk("model block_count", int'(block_count), m_blocks);
      chk("model timeout_err", int'(timeout_err), int'(m_to));
      for (int i = 0; i < 16; i++) chk("model array_numbers", int'(an[i]), int'(m_bytes[i]));
    end
  end

  task automatic step(input bit v, input logic [7:0] b, input bit d);
    in_valid = v; in_byte = b; core_done = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit v, input bit d);
    reset = 1'b1;
    step(v, 8'h55, d);
    step(v, 8'h66, d);
    reset = 1'b0;
    in_valid = 1'b0; core_done = 1'b0;
  endtask

  task automatic load_block(input logic [7:0] base);
    for (int k = 0; k < 16; k++) step(1'b1, base + 8'(k), 1'b0);
  endtask

  initial begin
    do_reset(1'b0, 1'b0);
    chk_en = 1'b1;
    $display("reset released");
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset core_ready", int'(core_ready), 0);
    chk("reset block_count", int'(block_count), 0);
    chk("reset array0", int'(an[0]), 0);

    // Back-to-back stream 0x00..0x0F
    for (int k = 0; k < 15; k++) step(1'b1, 8'(k), 1'b0);
    chk("stream pre-last core_ready", int'(core_ready), 0);
    step(1'b1, 8'h0F, 1'b0);
    $display("stream block loaded");
    chk("stream core_ready", int'(core_ready), 1);
    chk("stream in_ready", int'(in_ready), 0);
    for (int k = 0; k < 16; k++) chk("stream array", int'(an[k]), k);

    // Bytes offered during RUN must be ignored; done on the 33rd edge
    for (int c = 0; c < 32; c++) step(1'b1, 8'hEE, 1'b0);
    chk("run core_ready before done", int'(core_ready), 1);
    step(1'b1, 8'hEE, 1'b1);
    $display("core_done pulsed");
    chk("done core_ready", int'(core_ready), 0);
    chk("done block_count", int'(block_count), 1);
    chk("done timeout_err", int'(timeout_err), 0);
    chk("gap in_ready", int'(in_ready), 0);
    step(1'b0, 8'h00, 1'b1);
    chk("gap2 in_ready", int'(in_ready), 0);
    step(1'b0, 8'h00, 1'b1);
    chk("after gap in_ready", int'(in_ready), 1);
    chk("after gap block_count", int'(block_count), 1);
    chk("gap array15 kept", int'(an[15]), 15);

    // Toggling valid: 16th valid byte lands on the 31st cycle
    for (int i = 0; i < 30; i++) step(i % 2 == 0, 8'(i / 2), 1'b0);
    chk("toggle pre-last core_ready", int'(core_ready), 0);
    step(1'b1, 8'h0F, 1'b0);
    $display("toggled block loaded");
    chk("toggle core_ready", int'(core_ready), 1);
    for (int k = 0; k < 16; k++) chk("toggle array", int'(an[k]), k);

    // Watchdog expiry after 63 RUN cycles
    for (int c = 0; c < TIMEOUT - 1; c++) step(1'b0, 8'h00, 1'b0);
    chk("pre-timeout core_ready", int'(core_ready), 1);
    chk("pre-timeout timeout_err", int'(timeout_err), 0);
    step(1'b0, 8'h00, 1'b0);
    $display("watchdog expired");
    chk("timeout timeout_err", int'(timeout_err), 1);
    chk("timeout core_ready", int'(core_ready), 0);
    chk("timeout block_count", int'(block_count), 2);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    load_block(8'h30);
    step(1'b0, 8'h00, 1'b1);
    $display("block after timeout done");
    chk("sticky timeout_err", int'(timeout_err), 1);
    chk("post-timeout block_count", int'(block_count), 3);
    chk("post-timeout array5", int'(an[5]), 'h35);

    // Done arriving on the last allowed RUN cycle is a normal completion
    do_reset(1'b0, 1'b0);
    load_block(8'h40);
    for (int c = 0; c < TIMEOUT - 1; c++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    $display("done on watchdog edge");
    chk("edge-done timeout_err", int'(timeout_err), 0);
    chk("edge-done block_count", int'(block_count), 1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Reset after 7 bytes (reset beats valid and done), then fresh block
    for (int k = 0; k < 7; k++) step(1'b1, 8'h50 + 8'(k), 1'b0);
    do_reset(1'b1, 1'b1);
    $display("reset mid-load");
    chk("midload block_count", int'(block_count), 0);
    chk("midload array0", int'(an[0]), 0);
    chk("midload in_ready", int'(in_ready), 1);
    load_block(8'hA0);
    for (int k = 0; k < 16; k++) chk("fresh array", int'(an[k]), 'hA0 + k);
    step(1'b0, 8'h00, 1'b0);
    chk("fresh block_count before done", int'(block_count), 0);
    do_reset(1'b0, 1'b1);
    $display("reset mid-run");
    chk("midrun block_count", int'(block_count), 0);
    chk("midrun core_ready", int'(core_ready), 0);

    // 256 minimum-length blocks wrap block_count
    for (int b = 0; b < 256; b++) begin
      load_block(8'(b));
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
      if (b == 254) chk("count 255", int'(block_count), 255);
    end
    $display("block_count wrapped");
    chk("wrap block_count", int'(block_count), 0);
    chk("wrap in_ready", int'(in_ready), 1);
    chk("wrap array3", int'(an[3]), 'h02);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
